sram_ctrl: RTL and testbench
============================

# sram_ctrl

Parametrised asynchronous-SRAM controller for the Nexys2 board family and successors, replacing the fixed 8-bit switch/button test controller. Sits between a single-master valid/ready request port and the external SRAM pins. Generalises address width, data width, byte lanes and read/write wait states, and adds a response channel so a CPU or DMA master can use it directly.

## Interface
- `ADR_W`, 19: SRAM word-address width.
- `DAT_W`, 16: data width; must be a multiple of 8.
- `BE_W`, `DAT_W/8`: byte-lane count (derived, not overridable).
- `RD_WAIT`, 1: extra read cycles beyond the minimum, 0..15.
- `WR_WAIT`, 1: extra we_n-low cycles beyond the minimum, 0..15.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept.
- `req_we`  in  1  1 = write, 0 = read.
- `req_adr`  in  ADR_W  word address.
- `req_wdat`  in  DAT_W  write data.
- `req_be`  in  BE_W  byte enables, active-high; ignored on reads (all lanes read).
- `rsp_valid`  out  1  one-cycle completion pulse (reads and writes).
- `rsp_rdat`  out  DAT_W  read data; updated only by reads.
- `sram_adr`  out  ADR_W  SRAM address.
- `sram_dat_o`  out  DAT_W  data to pad.
- `sram_dat_oe`  out  1  pad drive enable.
- `sram_dat_i`  in  DAT_W  data from pad.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1  SRAM strobes.
- `sram_be_n`  out  BE_W  SRAM byte-lane strobes (ub/lb for 16 bits).

## Operation
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, plus TURN when the turnaround option is compiled in.
- `req_ready = (state == IDLE)`. A request is accepted on any edge where `req_valid && req_ready`; address, data and enables are registered on that edge.
- Read sequence:
  - RD drives ce_n=0, oe_n=0, be_n all 0, dat_oe=0.
  - RD is held for RD_WAIT+1 cycles under a down-counter.
  - On the last RD edge, `sram_dat_i` is captured into `rsp_rdat` and `rsp_valid` is set.
  - The FSM then goes to IDLE (or TURN).
- Write sequence:
  - WR_SETUP, 1 cycle: ce_n=0, dat_oe=1, be_n=~be, we_n=1.
  - WR_PULSE, WR_WAIT+1 cycles: we_n=0.
  - WR_HOLD, 1 cycle: we_n=1, data still driven.
  - Then IDLE, with `rsp_valid` pulsed and dat_oe=0.
- All SRAM outputs are registered; no combinational path from `sram_dat_i` to any output.
- `sram_adr` and `sram_dat_o` hold their last value in IDLE.
- Reset values:
  - state IDLE, req_ready=1.
  - rsp_valid=0, rsp_rdat=0.
  - sram_adr=0, sram_dat_o=0, dat_oe=0.
  - ce_n=oe_n=we_n=1, be_n all 1.
  - counter 0.
- Reset mid-access: the strobes deassert asynchronously, no rsp_valid is produced, and the access is lost.
- A write with `req_be == 0` still runs the full sequence with be_n all 1 (no lane written) and still responds.
- `req_valid` dropping while not ready has no effect; requests are not queued.

## Timing
- Accept at edge E0.
- Read: `rsp_valid` is high in the cycle after edge E0+RD_WAIT+1. Minimum latency is 1+RD_WAIT+1 edges.
- Write: `rsp_valid` is high in the cycle after edge E0+WR_WAIT+3.
- Back-to-back: the next accept is possible on the edge that ends the rsp_valid cycle. Peak read throughput is one access per RD_WAIT+2 cycles.
- During a write, we_n low never overlaps dat_oe=0, and never overlaps an address change.

## Configuration
- `SRAM_CTRL_TURNAROUND_EN` defined:
  - After every read, the FSM spends one TURN cycle before IDLE: ce_n=1, oe_n=1, dat_oe=0, req_ready=0.
  - `rsp_valid` is asserted during TURN, so read latency is unchanged but read throughput drops by one cycle.
  - Writes are unaffected.
- Undefined: RD returns directly to IDLE and there is no TURN state.

## Structure
- `sram_ctrl_pkg` holds:
  - the FSM state enum;
  - default `ADR_W`/`DAT_W` localparams for the Nexys2 (19/16);
  - the wait-counter width constant (4).
- One sub-module, `sram_ctrl_timer`: a loadable 4-bit down-counter with a `done` output, shared by RD and WR_PULSE.

## Test plan
Parameters: DAT_W=16, RD_WAIT=1, WR_WAIT=2.
- Reset held, then released → all strobes 1, dat_oe=0, req_ready=1, rsp_valid=0.
- Write adr 0x12345, data 0xA55A, be=2'b11 → WR_SETUP 1 cycle, we_n low exactly 3 cycles, hold 1 cycle, rsp_valid 1 cycle after edge E0+5; the SRAM model holds 0xA55A.
- Write be=2'b01 with data 0xBEEF over the stored 0xA55A, then read the same address → rsp_rdat=0xA5EF, rsp_valid after edge E0+2, oe_n low for 2 cycles.
- Two reads issued back-to-back with req_valid held high → second accepted the edge after the first rsp_valid; with SRAM_CTRL_TURNAROUND_EN, one cycle later.
- reset_n asserted while in WR_PULSE → we_n/ce_n high immediately (asynchronously), no rsp_valid, req_ready=1 after release.
- RD_WAIT=0 build, read adr 0 returning 0x00F0 → rsp_rdat=0x00F0, rsp_valid after edge E0+1.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the asynchronous-SRAM controller.
// Optional feature macro: SRAM_CTRL_TURNAROUND_EN (adds the TURN state after reads).
package sram_ctrl_pkg;

  // Nexys2 defaults for the SRAM geometry
  localparam int DEF_ADR_W = 19;
  localparam int DEF_DAT_W = 16;

  // Width of the shared wait-state counter (wait values 0..15)
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
`ifdef SRAM_CTRL_TURNAROUND_EN
    ,
    TURN     = 3'd5
`endif
  } state_t;

  // Truncate a wait-state parameter to the counter width
  function automatic logic [CNT_W-1:0] wait_load(input int w);
    return w[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sram_ctrl_timer.sv
// sram_ctrl_timer: loadable down-counter; done is high while the count is zero.
// Shared by the read phase and the write-pulse phase.
module sram_ctrl_timer
  import sram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Load on request, otherwise count down and stick at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= {CNT_W{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (count != {CNT_W{1'b0}}) begin
      count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign done = (count == {CNT_W{1'b0}});

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready request port to asynchronous SRAM pins, with a
// one-cycle response pulse. All pad-side outputs are registered.
// Optional feature macro: SRAM_CTRL_TURNAROUND_EN (one idle TURN cycle after each read).
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int ADR_W   = DEF_ADR_W,
  parameter  int DAT_W   = DEF_DAT_W,
  parameter  int RD_WAIT = 1,
  parameter  int WR_WAIT = 1,
  localparam int BE_W    = DAT_W / 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ADR_W-1:0] req_adr,
  input  logic [DAT_W-1:0] req_wdat,
  input  logic [BE_W-1:0]  req_be,
  output logic             rsp_valid,
  output logic [DAT_W-1:0] rsp_rdat,
  output logic [ADR_W-1:0] sram_adr,
  output logic [DAT_W-1:0] sram_dat_o,
  output logic             sram_dat_oe,
  input  logic [DAT_W-1:0] sram_dat_i,
  output logic             sram_ce_n,
  output logic             sram_oe_n,
  output logic             sram_we_n,
  output logic [BE_W-1:0]  sram_be_n
);

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic [BE_W-1:0]  be;
  logic [BE_W-1:0]  be_next;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_done;
  logic             rd_last;

  // Next-cycle values of the registered strobes
  logic             ce_n_d;
  logic             oe_n_d;
  logic             we_n_d;
  logic [BE_W-1:0]  be_n_d;
  logic             dat_oe_d;
  logic             rsp_valid_d;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign rd_last   = (state == RD) && timer_done;

  sram_ctrl_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = req_we ? WR_SETUP : RD;
        end else begin
          next_state = IDLE;
        end
      end
      RD: begin
        if (timer_done) begin
`ifdef SRAM_CTRL_TURNAROUND_EN
          next_state = TURN;
`else
          next_state = IDLE;
`endif
        end else begin
          next_state = RD;
        end
      end
      WR_SETUP: next_state = WR_PULSE;
      WR_PULSE: begin
        if (timer_done) begin
          next_state = WR_HOLD;
        end else begin
          next_state = WR_PULSE;
        end
      end
      WR_HOLD:  next_state = IDLE;
`ifdef SRAM_CTRL_TURNAROUND_EN
      TURN:     next_state = IDLE;
`endif
      default:  next_state = IDLE;
    endcase
  end

  // Timer loads: read wait on accepting a read, pulse width on leaving setup
  always_comb begin
    timer_load = 1'b0;
    timer_val  = {CNT_W{1'b0}};
    if (accept && !req_we) begin
      timer_load = 1'b1;
      timer_val  = wait_load(RD_WAIT);
    end else if (state == WR_SETUP) begin
      timer_load = 1'b1;
      timer_val  = wait_load(WR_WAIT);
    end else begin
      timer_load = 1'b0;
      timer_val  = {CNT_W{1'b0}};
    end
  end

  // Strobe values for the state being entered, so the pins change with the state
  always_comb begin
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    be_n_d      = {BE_W{1'b1}};
    dat_oe_d    = 1'b0;
    be_next     = accept ? req_be : be;
    rsp_valid_d = rd_last || (state == WR_HOLD);
    case (next_state)
      RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = {BE_W{1'b0}};
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_d   = 1'b0;
        be_n_d   = ~be_next;
        dat_oe_d = 1'b1;
      end
      WR_PULSE: begin
        ce_n_d   = 1'b0;
        we_n_d   = 1'b0;
        be_n_d   = ~be_next;
        dat_oe_d = 1'b1;
      end
      default: begin
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        be_n_d   = {BE_W{1'b1}};
        dat_oe_d = 1'b0;
      end
    endcase
  end

  // Output and request registers; reset drops every strobe immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_be_n   <= {BE_W{1'b1}};
      sram_dat_oe <= 1'b0;
      sram_adr    <= {ADR_W{1'b0}};
      sram_dat_o  <= {DAT_W{1'b0}};
      be          <= {BE_W{1'b0}};
      rsp_valid   <= 1'b0;
      rsp_rdat    <= {DAT_W{1'b0}};
    end else begin
      sram_ce_n   <= ce_n_d;
      sram_oe_n   <= oe_n_d;
      sram_we_n   <= we_n_d;
      sram_be_n   <= be_n_d;
      sram_dat_oe <= dat_oe_d;
      rsp_valid   <= rsp_valid_d;
      be          <= be_next;
      if (accept) begin
        sram_adr <= req_adr;
      end
      if (accept && req_we) begin
        sram_dat_o <= req_wdat;
      end
      if (rd_last) begin
        rsp_rdat <= sram_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed, self-checking bench for sram_ctrl with an SRAM model
// and a response scoreboard. A second instance covers the RD_WAIT=0 build.
module tb_sram_ctrl;

  localparam int ADR_W = 19;
  localparam int DAT_W = 16;
  localparam int BE_W  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             req_valid, req_ready, req_we;
  logic [ADR_W-1:0] req_adr;
  logic [DAT_W-1:0] req_wdat;
  logic [BE_W-1:0]  req_be;
  logic             rsp_valid;
  logic [DAT_W-1:0] rsp_rdat;
  logic [ADR_W-1:0] sram_adr;
  logic [DAT_W-1:0] sram_dat_o, sram_dat_i;
  logic             sram_dat_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [BE_W-1:0]  sram_be_n;

  logic             d0_valid, d0_ready, d0_we;
  logic [ADR_W-1:0] d0_req_adr;
  logic [DAT_W-1:0] d0_wdat;
  logic [BE_W-1:0]  d0_req_be;
  logic             d0_rsp_valid;
  logic [DAT_W-1:0] d0_rdat;
  logic [ADR_W-1:0] d0_adr;
  logic [DAT_W-1:0] d0_dat_o, d0_dat_i;
  logic             d0_dat_oe, d0_ce_n, d0_oe_n, d0_we_n;
  logic [BE_W-1:0]  d0_be_n;

  sram_ctrl #(.ADR_W(ADR_W), .DAT_W(DAT_W), .RD_WAIT(1), .WR_WAIT(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_wdat(req_wdat), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdat(rsp_rdat),
    .sram_adr(sram_adr), .sram_dat_o(sram_dat_o), .sram_dat_oe(sram_dat_oe),
    .sram_dat_i(sram_dat_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  sram_ctrl #(.ADR_W(ADR_W), .DAT_W(DAT_W), .RD_WAIT(0), .WR_WAIT(2)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(d0_valid), .req_ready(d0_ready), .req_we(d0_we),
    .req_adr(d0_req_adr), .req_wdat(d0_wdat), .req_be(d0_req_be),
    .rsp_valid(d0_rsp_valid), .rsp_rdat(d0_rdat),
    .sram_adr(d0_adr), .sram_dat_o(d0_dat_o), .sram_dat_oe(d0_dat_oe),
    .sram_dat_i(d0_dat_i), .sram_ce_n(d0_ce_n), .sram_oe_n(d0_oe_n),
    .sram_we_n(d0_we_n), .sram_be_n(d0_be_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DAT_W-1:0] mem [logic [ADR_W-1:0]];
  logic [DAT_W-1:0] sb_q [$];
  logic [DAT_W-1:0] sb0_q [$];

  // SRAM models: write lanes while ce_n/we_n low, drive read data while ce_n/oe_n low
  always @(negedge clk) begin
    logic [DAT_W-1:0] w;
    if (!sram_ce_n && !sram_we_n) begin
      w = mem.exists(sram_adr) ? mem[sram_adr] : 16'h0000;
      if (!sram_be_n[0]) w[7:0]  = sram_dat_o[7:0];
      if (!sram_be_n[1]) w[15:8] = sram_dat_o[15:8];
      mem[sram_adr] = w;
    end
    if (!sram_ce_n && !sram_oe_n && mem.exists(sram_adr)) sram_dat_i = mem[sram_adr];
    else sram_dat_i = 16'h0000;
    d0_dat_i = (!d0_ce_n && !d0_oe_n && d0_adr == 19'h00000) ? 16'h00F0 : 16'h0000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DAT_W-1:0] mem_rd(input logic [ADR_W-1:0] a);
    return mem.exists(a) ? mem[a] : 16'hxxxx;
  endfunction

  task automatic sb_pop_check(input string tag);
    logic [DAT_W-1:0] e;
    n_checks++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_underflow: observed unexpected response, expected none", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check(tag, rsp_rdat, e);
    end
  endtask

  int               we_low, oe_low, rsp_k, rsp_cnt, overlap;
  logic             setup_ok;
  logic [BE_W-1:0]  be_n_k0;
  logic [ADR_W-1:0] adr_k0;

  // Wait (bounded) for an accept edge; returns #1 after that edge
  task automatic wait_accept(output int ok);
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) ok = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [ADR_W-1:0] adr,
                           input logic [DAT_W-1:0] wd, input logic [BE_W-1:0] be);
    int ok;
    req_valid = 1'b1; req_we = we; req_adr = adr; req_wdat = wd; req_be = be;
    wait_accept(ok);
    req_valid = 1'b0;
    check("accept", ok, 1);
  endtask

  // Sample one cycle per negedge; k is the cycle after edge E0+k
  task automatic observe(input int ncyc);
    we_low = 0; oe_low = 0; rsp_k = -1; rsp_cnt = 0; overlap = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) begin
        setup_ok = (sram_we_n === 1'b1) && (sram_dat_oe === 1'b1) && (sram_ce_n === 1'b0);
        be_n_k0  = sram_be_n;
        adr_k0   = sram_adr;
      end
      if (sram_we_n === 1'b0) begin
        we_low++;
        if (sram_dat_oe !== 1'b1 || sram_adr !== adr_k0) overlap++;
      end
      if (sram_oe_n === 1'b0) oe_low++;
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        if (rsp_k < 0) rsp_k = k;
        sb_pop_check("rsp_rdat");
      end
    end
  endtask

  initial begin
    int ok, acc2_k, r1_k, r2_k, nrsp, exp_acc2, exp_r2;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_wdat = '0; req_be = '0;
    d0_valid = 1'b0; d0_we = 1'b0; d0_req_adr = '0; d0_wdat = '0; d0_req_be = '0;
    sram_dat_i = '0; d0_dat_i = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}, 5'b11111);
    check("rst_dat_oe", sram_dat_oe, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rdat", rsp_rdat, 16'h0000);
    check("rst_adr_dat", {sram_adr, sram_dat_o}, 35'h0);
    check("rst_d0", {d0_ce_n, d0_oe_n, d0_we_n, d0_be_n, d0_dat_oe, d0_ready, d0_rsp_valid},
          8'b11111010);
    check("rst_d0_dat", {d0_dat_o, d0_rdat}, 32'h0);

    // Full-lane write
    sb_q.push_back(16'h0000);
    start_req(1'b1, 19'h12345, 16'hA55A, 2'b11);
    observe(10);
    check("wr1_setup", setup_ok, 1'b1);
    check("wr1_be_n", be_n_k0, 2'b00);
    check("wr1_adr", adr_k0, 19'h12345);
    check("wr1_we_low", we_low, 3);
    check("wr1_rsp_k", rsp_k, 5);
    check("wr1_rsp_cnt", rsp_cnt, 1);
    check("wr1_overlap", overlap, 0);
    check("wr1_mem", mem_rd(19'h12345), 16'hA55A);
    check("wr1_idle", {sram_ce_n, sram_we_n, sram_dat_oe, req_ready}, 4'b1101);

    // Low-lane write then read back the merged word
    sb_q.push_back(16'h0000);
    start_req(1'b1, 19'h12345, 16'hBEEF, 2'b01);
    observe(10);
    check("wr2_be_n", be_n_k0, 2'b10);
    check("wr2_rsp_k", rsp_k, 5);
    check("wr2_mem", mem_rd(19'h12345), 16'hA5EF);

    sb_q.push_back(16'hA5EF);
    start_req(1'b0, 19'h12345, 16'h0000, 2'b00);
    observe(8);
    check("rd1_oe_low", oe_low, 2);
    check("rd1_rsp_k", rsp_k, 2);
    check("rd1_rsp_cnt", rsp_cnt, 1);
    check("rd1_be_n", be_n_k0, 2'b00);
    check("rd1_we_low", we_low, 0);

    // Write with no lanes enabled: full sequence, no change, rsp_rdat kept
    sb_q.push_back(16'hA5EF);
    start_req(1'b1, 19'h12345, 16'h1111, 2'b00);
    observe(10);
    check("wr0_be_n", be_n_k0, 2'b11);
    check("wr0_we_low", we_low, 3);
    check("wr0_rsp_k", rsp_k, 5);
    check("wr0_mem", mem_rd(19'h12345), 16'hA5EF);

    sb_q.push_back(16'hA5EF);
    start_req(1'b1, 19'h00077, 16'h1234, 2'b11);
    observe(10);
    check("wr3_rsp_k", rsp_k, 5);

    // Back-to-back reads with req_valid held high
`ifdef SRAM_CTRL_TURNAROUND_EN
    exp_acc2 = 3; exp_r2 = 6;
`else
    exp_acc2 = 2; exp_r2 = 5;
`endif
    sb_q.push_back(16'hA5EF);
    sb_q.push_back(16'h1234);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 19'h12345; req_be = 2'b11;
    wait_accept(ok);
    check("b2b_accept1", ok, 1);
    req_adr = 19'h00077;
    acc2_k = -1; r1_k = -1; r2_k = -1; nrsp = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        nrsp++;
        if (r1_k < 0) r1_k = k; else if (r2_k < 0) r2_k = k;
        sb_pop_check("b2b_rdat");
      end
      if (req_ready === 1'b1 && acc2_k < 0) begin
        acc2_k = k;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_r1_k", r1_k, 2);
    check("b2b_acc2_k", acc2_k, exp_acc2);
    check("b2b_r2_k", r2_k, exp_r2);
    check("b2b_nrsp", nrsp, 2);

    // Reset during the write pulse
    start_req(1'b1, 19'h00100, 16'hCAFE, 2'b11);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_in_pulse", sram_we_n, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_strobes", {sram_we_n, sram_ce_n, sram_dat_oe}, 3'b110);
    check("rstmid_rsp", rsp_valid, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    observe(6);
    check("rstmid_rsp_cnt", rsp_cnt, 0);
    check("rstmid_ready", req_ready, 1'b1);
    check("rstmid_rdat", rsp_rdat, 16'h0000);

    // RD_WAIT=0 instance: single-cycle read
    sb0_q.push_back(16'h00F0);
    d0_valid = 1'b1; d0_we = 1'b0; d0_req_adr = 19'h00000;
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      @(negedge clk);
      if (d0_ready === 1'b1) ok = 1;
    end
    @(posedge clk);
    #1 d0_valid = 1'b0;
    check("d0_accept", ok, 1);
    r1_k = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (d0_rsp_valid === 1'b1 && r1_k < 0) begin
        r1_k = k;
        check("d0_sb_nonempty", sb0_q.size(), 1);
        if (sb0_q.size() != 0) check("d0_rdat", d0_rdat, sb0_q.pop_front());
      end
    end
    check("d0_rsp_k", r1_k, 1);

    check("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
